// File: rtl/mouse_packet_tracker.sv
// PS/2 mouse packet framer and absolute position tracker (3- or 4-byte packets).
// Optional wheel accumulator on Z_POS is built only when MOUSE_Z_ACCUM_EN is defined.
module mouse_packet_tracker #(
  parameter int COORD_W     = 10,
  parameter int LIMIT_X     = 640,
  parameter int LIMIT_Y     = 480,
  parameter int Y_INVERT    = 1,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         BYTE_IN,
  input  logic               BYTE_VALID,
  input  logic               WHEEL_MODE,
  input  logic [1:0]         SPEED_SHIFT,
  input  logic               SET_POS,
  input  logic [COORD_W-1:0] SET_X,
  input  logic [COORD_W-1:0] SET_Y,
  output logic [COORD_W-1:0] POS_X,
  output logic [COORD_W-1:0] POS_Y,
  output logic [7:0]         STATUS,
  output logic [7:0]         DX,
  output logic [7:0]         DY,
  output logic [3:0]         DZ,
  output logic [7:0]         Z_POS,
  output logic               PKT_VALID,
  output logic               SYNC_ERR,
  output logic [2:0]         FSM_STATE
);

  localparam int CW = COORD_W + 4;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [2:0] B0     = 3'd0;
  localparam logic [2:0] B1     = 3'd1;
  localparam logic [2:0] B2     = 3'd2;
  localparam logic [2:0] B3     = 3'd3;
  localparam logic [2:0] UPDATE = 3'd4;

  localparam logic signed [CW-1:0] MAX_X = CW'(LIMIT_X - 1);
  localparam logic signed [CW-1:0] MAX_Y = CW'(LIMIT_Y - 1);

  logic [2:0]         state;
  logic               wheelLat;
  logic [7:0]         byte0;
  logic [7:0]         byte1;
  logic [7:0]         byte2;
  logic [3:0]         byte3;
  logic [TW-1:0]      gapCnt;
  logic               timeout;
  logic signed [CW-1:0] dxScaled;
  logic signed [CW-1:0] dyScaled;
  logic signed [CW-1:0] newX;
  logic signed [CW-1:0] newY;
  logic [COORD_W-1:0] updX;
  logic [COORD_W-1:0] updY;
  logic [COORD_W-1:0] setXc;
  logic [COORD_W-1:0] setYc;
  logic [3:0]         dzNext;

  assign FSM_STATE = state;

  // Overflow saturates the 9-bit delta before scaling; shift applies after sign extension.
  function automatic logic signed [CW-1:0] scaleDelta(input logic [7:0] b, input logic sgn,
                                                      input logic ovf, input logic [1:0] sh);
    logic [8:0]           d;
    logic signed [CW-1:0] ext;
    d   = ovf ? (sgn ? 9'h100 : 9'h0FF) : {sgn, b};
    ext = {{(CW-9){d[8]}}, d};
    return ext <<< sh;
  endfunction

  function automatic logic [COORD_W-1:0] clampPos(input logic signed [CW-1:0] v,
                                                  input logic signed [CW-1:0] maxV);
    logic [COORD_W-1:0] r;
    if (v[CW-1])       r = '0;
    else if (v > maxV) r = maxV[COORD_W-1:0];
    else               r = v[COORD_W-1:0];
    return r;
  endfunction

  always_comb begin
    timeout  = (state == B1 || state == B2 || state == B3) && (gapCnt == TW'(TIMEOUT_CYC));
    dxScaled = scaleDelta(byte1, byte0[4], byte0[6], SPEED_SHIFT);
    dyScaled = scaleDelta(byte2, byte0[5], byte0[7], SPEED_SHIFT);
    newX     = $signed({4'b0000, POS_X}) + dxScaled;
    newY     = (Y_INVERT != 0) ? $signed({4'b0000, POS_Y}) - dyScaled
                               : $signed({4'b0000, POS_Y}) + dyScaled;
    updX     = clampPos(newX, MAX_X);
    updY     = clampPos(newY, MAX_Y);
    setXc    = clampPos($signed({4'b0000, SET_X}), MAX_X);
    setYc    = clampPos($signed({4'b0000, SET_Y}), MAX_Y);
    dzNext   = wheelLat ? byte3 : 4'h0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= B0;
      wheelLat  <= 1'b0;
      byte0     <= 8'h00;
      byte1     <= 8'h00;
      byte2     <= 8'h00;
      byte3     <= 4'h0;
      gapCnt    <= '0;
      POS_X     <= COORD_W'(LIMIT_X / 2);
      POS_Y     <= COORD_W'(LIMIT_Y / 2);
      STATUS    <= 8'h00;
      DX        <= 8'h00;
      DY        <= 8'h00;
      DZ        <= 4'h0;
      PKT_VALID <= 1'b0;
      SYNC_ERR  <= 1'b0;
    end else begin
      PKT_VALID <= 1'b0;
      SYNC_ERR  <= 1'b0;
      // A timeout abandons the partial packet; a coincident strobe is a fresh byte0.
      if (state == B0 || timeout) begin
        gapCnt <= '0;
        if (timeout) SYNC_ERR <= 1'b1;
        if (BYTE_VALID && BYTE_IN[3]) begin
          byte0    <= BYTE_IN;
          wheelLat <= WHEEL_MODE;
          state    <= B1;
        end else begin
          state <= B0;
          if (BYTE_VALID) SYNC_ERR <= 1'b1;
        end
      end else begin
        case (state)
          B1, B2, B3: begin
            if (BYTE_VALID) begin
              gapCnt <= '0;
              if (state == B1) begin
                byte1 <= BYTE_IN;
                state <= B2;
              end else if (state == B2) begin
                byte2 <= BYTE_IN;
                state <= wheelLat ? B3 : UPDATE;
              end else begin
                byte3 <= BYTE_IN[3:0];
                state <= UPDATE;
              end
            end else begin
              gapCnt <= gapCnt + TW'(1);
            end
          end
          UPDATE: begin
            STATUS    <= byte0;
            DX        <= byte1;
            DY        <= byte2;
            DZ        <= dzNext;
            POS_X     <= updX;
            POS_Y     <= updY;
            PKT_VALID <= 1'b1;
            state     <= B0;
          end
          default: state <= B0;
        endcase
      end
      if (SET_POS) begin
        POS_X <= setXc;
        POS_Y <= setYc;
      end
    end
  end

`ifdef MOUSE_Z_ACCUM_EN
  logic signed [8:0] zSum;

  always_comb zSum = $signed({Z_POS[7], Z_POS}) + $signed({{5{dzNext[3]}}, dzNext});

  always_ff @(posedge CLK) begin
    if (RESET) begin
      Z_POS <= 8'h00;
    end else if (state == UPDATE) begin
      if (zSum > 9'sd127)       Z_POS <= 8'h7F;
      else if (zSum < -9'sd128) Z_POS <= 8'h80;
      else                      Z_POS <= zSum[7:0];
    end
  end
`else
  assign Z_POS = 8'h00;
`endif

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Scoreboard bench for mouse_packet_tracker: directed cases plus randomized packets
// checked against an integer-arithmetic reference model.
module tb_mouse_packet_tracker;

  localparam int TIMEOUT = 64;
  localparam int LIM_X   = 640;
  localparam int LIM_Y   = 480;
  localparam int EXP_W   = 56;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [3:0] dz;
    logic [9:0] px;
    logic [9:0] py;
    logic [7:0] z;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       wheel_mode = 1'b0;
  logic [1:0] speed_shift = 2'd0;
  logic       set_pos = 1'b0;
  logic [9:0] set_x = '0;
  logic [9:0] set_y = '0;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic [7:0] status;
  logic [7:0] dx;
  logic [7:0] dy;
  logic [3:0] dz;
  logic [7:0] z_pos;
  logic       pkt_valid;
  logic       sync_err;
  logic [2:0] fsm_state;

  logic [EXP_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;
  int               sync_pending = 0;
  bit               mon_en = 1'b0;

  int model_x = LIM_X / 2;
  int model_y = LIM_Y / 2;
  int model_z = 0;

  mouse_packet_tracker #(
    .COORD_W(10), .LIMIT_X(LIM_X), .LIMIT_Y(LIM_Y), .Y_INVERT(1), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .CLK(clk), .RESET(reset), .BYTE_IN(byte_in), .BYTE_VALID(byte_valid),
    .WHEEL_MODE(wheel_mode), .SPEED_SHIFT(speed_shift), .SET_POS(set_pos),
    .SET_X(set_x), .SET_Y(set_y), .POS_X(pos_x), .POS_Y(pos_y), .STATUS(status),
    .DX(dx), .DY(dy), .DZ(dz), .Z_POS(z_pos), .PKT_VALID(pkt_valid),
    .SYNC_ERR(sync_err), .FSM_STATE(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model
  function automatic int mdelta(input logic [7:0] b, input logic sgn, input logic ovf,
                                input logic [1:0] sh);
    int d;
    if (ovf) d = sgn ? -256 : 255;
    else     d = sgn ? int'(b) - 256 : int'(b);
    return d * (1 << sh);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // driver tasks
  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_pos(input string name);
    check({name, "_x"}, int'(pos_x), model_x);
    check({name, "_y"}, int'(pos_y), model_y);
  endtask

  task automatic send_packet(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                             input logic [7:0] p3, input logic wheel, input logic [1:0] sh,
                             input bit set_upd, input int sx, input int sy);
    logic [7:0] bs[4];
    exp_t       e;
    int         n;
    int         dzi;
    bs[0] = p0; bs[1] = p1; bs[2] = p2; bs[3] = p3;
    n = wheel ? 4 : 3;
    dzi = 0;
    if (wheel) dzi = p3[3] ? int'(p3[3:0]) - 16 : int'(p3[3:0]);
    model_x = clampi(model_x + mdelta(p1, p0[4], p0[6], sh), 0, LIM_X - 1);
    model_y = clampi(model_y - mdelta(p2, p0[5], p0[7], sh), 0, LIM_Y - 1);
`ifdef MOUSE_Z_ACCUM_EN
    model_z = clampi(model_z + dzi, -128, 127);
`endif
    if (set_upd) begin
      model_x = clampi(sx, 0, LIM_X - 1);
      model_y = clampi(sy, 0, LIM_Y - 1);
    end
    e.st = p0; e.dx = p1; e.dy = p2; e.dz = 4'(dzi);
    e.px = 10'(model_x); e.py = 10'(model_y); e.z = 8'(model_z);
    wheel_mode  = wheel;
    speed_shift = sh;
    for (int i = 0; i < n; i++) begin
      byte_in    = bs[i];
      byte_valid = 1'b1;
      if (i == n - 1) begin
        exp_q.push_back(e);
        exp_cyc_q.push_back(cyc + 2);
      end
      tick();
      byte_valid = 1'b0;
      if (i == n - 1 && set_upd) begin
        set_pos = 1'b1;
        set_x   = 10'(sx);
        set_y   = 10'(sy);
      end
      tick();
      set_pos = 1'b0;
      tick();
    end
  endtask

  task automatic send_bad(input logic [7:0] b);
    sync_pending++;
    byte_in    = b & 8'hF7;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic direct_set(input int sx, input int sy);
    set_pos = 1'b1;
    set_x   = 10'(sx);
    set_y   = 10'(sy);
    tick();
    set_pos = 1'b0;
    model_x = clampi(sx, 0, LIM_X - 1);
    model_y = clampi(sy, 0, LIM_Y - 1);
    check_pos("set_pos");
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (pkt_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pkt_unexpected: got PKT_VALID at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          int   ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          if ({status, dx, dy, dz, pos_x, pos_y, z_pos} != e) begin
            miscompares++;
            $display("FAIL pkt_fields: got st=%h dx=%h dy=%h dz=%h x=%0d y=%0d z=%h expected st=%h dx=%h dy=%h dz=%h x=%0d y=%0d z=%h",
                     status, dx, dy, dz, pos_x, pos_y, z_pos,
                     e.st, e.dx, e.dy, e.dz, e.px, e.py, e.z);
          end
          vectors++;
          if (cyc != ec) begin
            miscompares++;
            $display("FAIL pkt_latency: got cycle %0d expected %0d", cyc, ec);
          end
        end
      end
      if (sync_err) begin
        vectors++;
        if (sync_pending == 0) begin
          miscompares++;
          $display("FAIL sync_unexpected: got SYNC_ERR at cycle %0d expected none", cyc);
        end else begin
          sync_pending--;
        end
      end
    end
  end

  initial begin
    int r;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_pos_x", int'(pos_x), 320);
    check("reset_pos_y", int'(pos_y), 240);
    check("reset_pkt_valid", int'(pkt_valid), 0);
    check("reset_sync_err", int'(sync_err), 0);
    check("reset_z_pos", int'(z_pos), 0);
    check("reset_status", int'(status), 0);
    mon_en = 1'b1;

    send_packet(8'h08, 8'h05, 8'h03, 8'h00, 1'b0, 2'd0, 1'b0, 0, 0);
    check_pos("basic");
    check("basic_pos_x", int'(pos_x), 325);
    check("basic_pos_y", int'(pos_y), 237);

    send_packet(8'h58, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 0, 0);
    check_pos("xovf1");
    send_packet(8'h58, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 0, 0);
    check("xovf_clamp_low", int'(pos_x), 0);
    send_packet(8'h08, 8'h7F, 8'h00, 8'h00, 1'b0, 2'd3, 1'b0, 0, 0);
    check("shift_clamp_high", int'(pos_x), 639);

    direct_set(320, 240);
    send_bad(8'h05);
    send_packet(8'h08, 8'h01, 8'h01, 8'h00, 1'b0, 2'd0, 1'b0, 0, 0);
    check("resync_pos_x", int'(pos_x), 321);
    check("resync_pos_y", int'(pos_y), 239);

    // partial packet abandoned by idle gap
    direct_set(320, 240);
    sync_pending++;
    wheel_mode = 1'b0;
    speed_shift = 2'd0;
    byte_in = 8'h08; byte_valid = 1'b1; tick(); byte_valid = 1'b0; tick(); tick();
    byte_in = 8'h05; byte_valid = 1'b1; tick(); byte_valid = 1'b0;
    repeat (TIMEOUT + 10) tick();
    check_pos("timeout_unchanged");
    send_packet(8'h08, 8'h02, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 0, 0);
    check("timeout_next_x", int'(pos_x), 322);

    send_packet(8'h08, 8'h00, 8'h00, 8'h0F, 1'b1, 2'd0, 1'b1, 10, 20);
    check("wheel_dz", int'(dz), 15);
    check("wheel_set_x", int'(pos_x), 10);
    check("wheel_set_y", int'(pos_y), 20);
`ifdef MOUSE_Z_ACCUM_EN
    check("wheel_z", int'(z_pos), 8'hFF);
`else
    check("wheel_z", int'(z_pos), 0);
`endif

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        send_bad(8'($urandom_range(0, 255)));
      end else if (r == 1) begin
        direct_set($urandom_range(0, 1023), $urandom_range(0, 1023));
      end else begin
        send_packet(8'($urandom_range(0, 255)) | 8'h08, 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 1023), $urandom_range(0, 1023));
        check_pos("rand_pkt");
      end
    end

    for (int i = 0; i < 20 && (exp_q.size() != 0 || sync_pending != 0); i++) tick();
    check("drain_pkt_queue", exp_q.size(), 0);
    check("drain_sync_pending", sync_pending, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
